sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 104 ++++++++++
 tb/tb_sw_debounce.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// ============================================================================
// Module   : sw_debounce
// Brief    : N-channel slide-switch debouncer. Each channel has a two-flop
//            synchronizer and a stability counter. Optional registered
//            rise/fall pulses are enabled by defining SW_DEBOUNCE_EDGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_busy
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || N_SW < 1) begin : g_param_check
            $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2 and N_SW >= 1");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    logic   [N_SW-1:0]            sync1;
    logic   [N_SW-1:0]            sync2;
    logic   [N_SW-1:0]            clean_nxt;
    logic   [N_SW-1:0][CNT_W-1:0] cnt;
    logic   [N_SW-1:0][CNT_W-1:0] cnt_nxt;
    state_e [N_SW-1:0]            state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sw_clean <= '0;
            cnt      <= '0;
        end else begin
            sync1    <= SW;
            sync2    <= sync1;
            sw_clean <= clean_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // A channel is counting exactly while its synchronized input disagrees
    // with the accepted level; the terminal compare wins over increment.
    always_comb begin
        clean_nxt = sw_clean;
        cnt_nxt   = '0;
        state     = '{default: ST_IDLE};
        for (int i = 0; i < N_SW; i++) begin
            state[i] = (sync2[i] != sw_clean[i]) ? ST_COUNT : ST_IDLE;
            case (state[i])
                ST_IDLE: begin
                    cnt_nxt[i] = '0;
                end
                ST_COUNT: begin
                    if (cnt[i] == CNT_LAST) begin
                        clean_nxt[i] = sync2[i];
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    assign sw_busy = |cnt;

`ifdef SW_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= clean_nxt & ~sw_clean;
            sw_fall <= ~clean_nxt & sw_clean;
        end
    end
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce.sv
// ============================================================================
// Module   : tb_sw_debounce
// Brief    : Directed + randomized bench for sw_debounce, using a history-based
//            reference model ("last DEBOUNCE_CYCLES synchronized samples").
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_debounce;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw;
    logic [N-1:0] sw_clean;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_busy;

    always #5 clk = ~clk;

    sw_debounce #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SW       (sw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_busy  (sw_busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Raw SW value sampled at each post-reset edge, newest at the back.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_clean;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic         m_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sample taken k edges ago; before any sample exists the synchronizer holds 0.
    function automatic logic [N-1:0] past(input int k);
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    // The synchronized level seen by the edge just taken is the sample from
    // two edges back; a level is accepted once D such samples in a row differ.
    task automatic model_edge(input logic [N-1:0] s);
        logic [N-1:0] prev;
        logic [N-1:0] smp;
        logic         stable;
        prev = m_clean;
        hist.push_back(s);
        if (hist.size() > D + 8) void'(hist.pop_front());
        for (int i = 0; i < N; i++) begin
            stable = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
                smp = past(k);
                if (smp[i] == prev[i]) stable = 1'b0;
            end
            if (stable) m_clean[i] = ~prev[i];
        end
`ifdef SW_DEBOUNCE_EDGE_EN
        m_rise = m_clean & ~prev;
        m_fall = ~m_clean & prev;
`else
        m_rise = '0;
        m_fall = '0;
`endif
        m_busy = |(past(2) ^ m_clean);
    endtask

    task automatic check_all(input string ph);
        check({ph, ".clean"}, 32'(sw_clean), 32'(m_clean));
        check({ph, ".rise"},  32'(sw_rise),  32'(m_rise));
        check({ph, ".fall"},  32'(sw_fall),  32'(m_fall));
        check({ph, ".busy"},  32'(sw_busy),  32'(m_busy));
    endtask

    task automatic model_clear();
        hist.delete();
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_busy  = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] v, input string ph);
        sw = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_all(ph);
    endtask

    // Reset asserted between edges must clear outputs without waiting for clk.
    task automatic pulse_reset(input int hold);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all("rst_async");
        repeat (hold) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] cur;
        int           r;
        reset = 1'b1;
        sw    = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Quiet inputs: nothing moves.
        repeat (20) step(4'b0000, "idle");

        // Single clean rising edge on SW[0], then release.
        repeat (10) step(4'b0001, "sw0_up");
        repeat (10) step(4'b0000, "sw0_dn");

        // Short bounce on SW[1] must be rejected.
        repeat (3)  step(4'b0010, "bounce");
        repeat (10) step(4'b0000, "bounce_rel");

        // Two channels changing together, then falling together.
        repeat (10) step(4'b1010, "multi_up");
        repeat (10) step(4'b0000, "multi_dn");

        // Reset in the middle of a count, then the held level is accepted.
        repeat (4)  step(4'b0100, "pre_rst");
        pulse_reset(2);
        repeat (10) step(4'b0100, "post_rst");
        repeat (10) step(4'b0000, "post_rst_dn");

        // Randomized bouncing with occasional resets.
        cur = '0;
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      cur = cur ^ N'(1 << $urandom_range(0, N - 1));
            else if (r == 1) cur = N'($urandom);
            if ($urandom_range(0, 399) == 0) pulse_reset(int'($urandom_range(1, 3)));
            step(cur, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
